// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
//   Issues word addresses to a 1-cycle-latency synchronous instruction memory,
//   buffers returned 16-bit instructions with their PCs in a DEPTH-entry queue,
//   and presents the queue head to decode. A taken branch from execute flushes
//   the queue, drops any in-flight response and redirects fetch.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   stall             - decode not accepting; head is held
//   is_branch_taken   - redirect/flush request (overrides stall)
//   branch_target     - word address to fetch after a taken branch
//   imem_rd_en/addr   - memory read request (combinational)
//   imem_rdata        - memory read data, one cycle after the request
//   instr/instr_pc    - head instruction and its address, zero when not valid
//   instr_valid       - head is valid this cycle
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        is_branch_taken,
   input  logic [15:0] branch_target,
   output logic        imem_rd_en,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   output logic        instr_valid
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [15:0]   fetch_pc;
   logic [15:0]   inflight_pc;
   logic          inflight;
   logic [15:0]   q_instr [DEPTH];
   logic [15:0]   q_pc    [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0]   count;
   logic [PW+1:0] occ;
   logic          issue, push, pop;

   // Occupancy counts the in-flight slot so a response always has room.
   assign occ   = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
   // Gating with reset keeps the request low while reset is held.
   assign issue = !reset && !is_branch_taken && (occ < (PW+2)'(DEPTH));
   assign push  = inflight && !is_branch_taken;
   assign pop   = instr_valid && !stall;

   assign imem_rd_en  = issue;
   assign imem_addr   = fetch_pc;
   assign instr_valid = (count != '0) && !is_branch_taken;
   assign instr       = instr_valid ? q_instr[rd_ptr] : 16'h0000;
   assign instr_pc    = instr_valid ? q_pc[rd_ptr]    : 16'h0000;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 16'h0000;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (is_branch_taken) begin
         // Flush everything; the last of back-to-back branches wins.
         fetch_pc <= branch_target;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 16'h0001;
         end
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + (PW+1)'(1);
         else if (pop && !push) count <= count - (PW+1)'(1);
      end
   end

   // Queue storage needs no reset: count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[wr_ptr] <= imem_rdata;
         q_pc[wr_ptr]    <= inflight_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Memory returns 16'h1000+addr
// one cycle after a read request. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        is_branch_taken;
   logic [15:0] branch_target;
   logic        imem_rd_en;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .is_branch_taken (is_branch_taken),
      .branch_target   (branch_target),
      .imem_rd_en      (imem_rd_en),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_valid     (instr_valid)
   );

   // Synchronous memory: mem[a] = 16'h1000 + a.
   always @(posedge clk) begin
      if (imem_rd_en) imem_rdata <= 16'h1000 + imem_addr;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cy();
      @(posedge clk);
      #1;
   endtask

   // Check head outputs at the falling edge of the current cycle.
   task automatic chk_head(input string tag, input logic v, input logic [15:0] i, input logic [15:0] p);
      @(negedge clk);
      chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
      chk({tag, ".instr"}, 32'(instr), 32'(i));
      chk({tag, ".pc"},    32'(instr_pc), 32'(p));
   endtask

   task automatic chk_req(input string tag, input logic en, input logic [15:0] a);
      chk({tag, ".rd_en"}, 32'(imem_rd_en), 32'(en));
      if (en) chk({tag, ".addr"}, 32'(imem_addr), 32'(a));
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; is_branch_taken = 1'b0;
      branch_target = 16'h0000; imem_rdata = 16'h0000;

      // Reset state
      cy(); cy();
      chk_head("rst", 1'b0, 16'h0000, 16'h0000);
      chk("rst.rd_en", 32'(imem_rd_en), 32'd0);
      chk("rst.addr",  32'(imem_addr),  32'h0000);

      // Cycle 0: first issue; valid appears in cycle 2
      cy(); reset = 1'b0;
      chk_head("c0", 1'b0, 16'h0000, 16'h0000);
      chk_req("c0", 1'b1, 16'h0000);
      cy();
      chk_head("c1", 1'b0, 16'h0000, 16'h0000);
      chk_req("c1", 1'b1, 16'h0001);
      for (int k = 2; k <= 4; k++) begin
         cy();
         chk_head($sformatf("stream%0d", k), 1'b1, 16'h1000 + 16'(k - 2), 16'(k - 2));
      end

      // Stall cycles 5..10 with head at pc 3; issue stops once full
      for (int k = 5; k <= 10; k++) begin
         cy(); stall = 1'b1;
         chk_head($sformatf("stall%0d", k), 1'b1, 16'h1003, 16'h0003);
         chk_req($sformatf("stall%0d", k), (k <= 6), 16'(k));
      end
      // Release: order 3..7 preserved
      for (int k = 11; k <= 15; k++) begin
         cy(); stall = 1'b0;
         chk_head($sformatf("rel%0d", k), 1'b1, 16'h1003 + 16'(k - 11), 16'h0003 + 16'(k - 11));
         if (k == 11) chk_req("rel11", 1'b0, 16'h0000);
         if (k == 12) chk_req("rel12", 1'b1, 16'h0007);
      end
      // Cycle 15 was shown unstalled; one stall cycle now leaves 3 queued + 1 in flight
      cy(); stall = 1'b1;
      chk_head("fill", 1'b1, 16'h1008, 16'h0008);

      // Branch to 0x40
      cy(); stall = 1'b0; is_branch_taken = 1'b1; branch_target = 16'h0040;
      chk_head("br", 1'b0, 16'h0000, 16'h0000);
      chk_req("br", 1'b0, 16'h0000);
      cy(); is_branch_taken = 1'b0;
      chk_head("br+1", 1'b0, 16'h0000, 16'h0000);
      chk_req("br+1", 1'b1, 16'h0040);
      cy();
      chk_head("br+2", 1'b0, 16'h0000, 16'h0000);
      cy();
      chk_head("br+3", 1'b1, 16'h1040, 16'h0040);
      cy();
      chk_head("br+4", 1'b1, 16'h1041, 16'h0041);

      // Branch with stall to 0xFFFE; stall held afterwards
      cy(); stall = 1'b1; is_branch_taken = 1'b1; branch_target = 16'hFFFE;
      chk_head("brst", 1'b0, 16'h0000, 16'h0000);
      cy(); is_branch_taken = 1'b0;
      chk_head("brst+1", 1'b0, 16'h0000, 16'h0000);
      chk_req("brst+1", 1'b1, 16'hFFFE);
      cy();
      chk_head("brst+2", 1'b0, 16'h0000, 16'h0000);
      cy();
      chk_head("brst+3", 1'b1, 16'h0FFE, 16'hFFFE);
      cy();
      chk_head("brst+4", 1'b1, 16'h0FFE, 16'hFFFE);
      // Release: FFFE, FFFF, 0000, 0001
      cy(); stall = 1'b0;
      chk_head("wrap0", 1'b1, 16'h0FFE, 16'hFFFE);
      cy();
      chk_head("wrap1", 1'b1, 16'h0FFF, 16'hFFFF);
      cy();
      chk_head("wrap2", 1'b1, 16'h1000, 16'h0000);
      cy();
      chk_head("wrap3", 1'b1, 16'h1001, 16'h0001);

      // Reset mid-cycle with count=2 and a request for pc 3 in flight
      #2 reset = 1'b1;
      #1;
      chk("mrst.valid", 32'(instr_valid), 32'd0);
      chk("mrst.instr", 32'(instr),       32'h0000);
      chk("mrst.pc",    32'(instr_pc),    32'h0000);
      chk("mrst.rd_en", 32'(imem_rd_en),  32'd0);
      chk("mrst.addr",  32'(imem_addr),   32'h0000);
      cy(); reset = 1'b0;
      chk_head("r0", 1'b0, 16'h0000, 16'h0000);
      chk_req("r0", 1'b1, 16'h0000);
      cy();
      chk_head("r1", 1'b0, 16'h0000, 16'h0000);
      cy();
      chk_head("r2", 1'b1, 16'h1000, 16'h0000);
      cy();
      chk_head("r3", 1'b1, 16'h1001, 16'h0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
